// File: rtl/deserializer.sv
// Serial-to-parallel receiver: LSB-first bits following a one-cycle start pulse
// are assembled into a WIDTH-bit word, published with a one-cycle valid strobe.
module deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             sync_err,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // One-hot encoding leaves illegal codes that the default branch recovers from.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    RECV = 2'b10
  } state_e;

  // Handshake: data_valid is a one-cycle strobe with no ready; data_out is
  // stable from that cycle until the next strobe.
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             last_bit;

  assign last_bit = (cnt_q == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (start && !last_bit) begin
          // Early start: drop the partial word and resynchronise.
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          shift_d[cnt_q] = serial_in;
          if (last_bit) begin
            dout_d  = shift_d;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = start ? RECV : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign sync_err   = err_q;
  assign busy       = (state_q == RECV);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: vector table for single and back-to-back
// frames, then resync, reset, idle noise, loopback and width sweep sequences.
module tb_deserializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       ser8 = 1'b0, st8 = 1'b0;
  logic [7:0] dout8;
  logic       valid8, busy8, err8;
  logic [1:0] dbg8;
  // WIDTH=2 instance
  logic       ser2 = 1'b0, st2 = 1'b0;
  logic [1:0] dout2;
  logic       valid2, busy2, err2;
  logic [1:0] dbg2;
  // WIDTH=32 instance
  logic        ser32 = 1'b0, st32 = 1'b0;
  logic [31:0] dout32;
  logic        valid32, busy32, err32;
  logic [1:0]  dbg32;

  deserializer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .serial_in(ser8), .start(st8),
    .data_out(dout8), .data_valid(valid8), .busy(busy8), .sync_err(err8),
    .dbg_state(dbg8)
  );
  deserializer #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .serial_in(ser2), .start(st2),
    .data_out(dout2), .data_valid(valid2), .busy(busy2), .sync_err(err2),
    .dbg_state(dbg2)
  );
  deserializer #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .serial_in(ser32), .start(st32),
    .data_out(dout32), .data_valid(valid32), .busy(busy32), .sync_err(err32),
    .dbg_state(dbg32)
  );

  typedef struct {
    logic       start;
    logic       ser;
    logic       valid;
    logic       busy;
    logic       err;
    logic [7:0] dout;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic ser, input logic v, input logic b,
                     input logic e, input logic [7:0] d);
    vec_t x;
    x.start = st; x.ser = ser; x.valid = v; x.busy = b; x.err = e; x.dout = d;
    vecs.push_back(x);
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_quiet8(input string tag, input logic [7:0] dout_exp);
    check({tag, " valid"}, valid8, 0);
    check({tag, " busy"}, busy8, 0);
    check({tag, " err"}, err8, 0);
    check({tag, " dout"}, dout8, dout_exp);
  endtask

  initial begin
    logic [7:0]  w;
    logic [1:0]  w2;
    logic [31:0] w32;
    int          pulses, last_cyc, cyc;

    // ---------------- vector table ----------------
    w = 8'h5A;
    add(1, 0, 0, 1, 0, 8'h00);
    for (int k = 0; k < 8; k++)
      add(0, w[k], k == 7, k != 7, 0, (k == 7) ? 8'h5A : 8'h00);
    add(0, 1, 0, 0, 0, 8'h5A);                       // idle, serial ignored
    add(1, 0, 0, 1, 0, 8'h5A);
    for (int k = 0; k < 8; k++)                      // FF, start on its last bit
      add(k == 7, 1, k == 7, 1, 0, (k == 7) ? 8'hFF : 8'h5A);
    for (int k = 0; k < 8; k++)                      // 00, zero gap
      add(0, 0, k == 7, k != 7, 0, (k == 7) ? 8'h00 : 8'hFF);
    add(0, 1, 0, 0, 0, 8'h00);

    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    check_quiet8("reset", 8'h00);
    check("reset state", dbg8, 2'b01);
    check("reset dout32", dout32, 0);
    rst_n = 1'b1;
    tick();
    check_quiet8("post-release", 8'h00);

    // ---------------- table replay ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      st8 = vecs[i].start;
      ser8 = vecs[i].ser;
      tick();
      check($sformatf("vec%0d valid", i), valid8, vecs[i].valid);
      check($sformatf("vec%0d busy", i), busy8, vecs[i].busy);
      check($sformatf("vec%0d err", i), err8, vecs[i].err);
      check($sformatf("vec%0d dout", i), dout8, vecs[i].dout);
    end

    // ---------------- resync: 4 bits, early start, then A5 ----------------
    st8 = 1; ser8 = 0; tick();
    st8 = 0;
    for (int k = 0; k < 4; k++) begin
      ser8 = 1; tick();
      check("resync partial valid", valid8, 0);
    end
    st8 = 1; ser8 = 0; tick();
    check("resync err pulse", err8, 1);
    check("resync busy", busy8, 1);
    check("resync dout held", dout8, 8'h00);
    st8 = 0;
    w = 8'hA5;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      ser8 = w[k]; tick();
      check("resync err low", err8, 0);
      check($sformatf("resync bit%0d valid", k), valid8, k == 7);
      check($sformatf("resync bit%0d dout", k), dout8, (k == 7) ? 8'hA5 : 8'h00);
      if (valid8) pulses++;
    end
    ser8 = 0; tick();
    check("resync valid count", pulses, 1);
    check("resync valid drop", valid8, 0);

    // ---------------- asynchronous reset mid-frame ----------------
    st8 = 1; tick();
    st8 = 0;
    for (int k = 0; k < 3; k++) begin
      ser8 = 1; tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check_quiet8("async reset", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ser8 = k[0]; tick();
      check_quiet8($sformatf("post-reset %0d", k), 8'h00);
    end

    // ---------------- idle noise ----------------
    for (int k = 0; k < 100; k++) begin
      ser8 = 1'($urandom_range(0, 1));
      tick();
      check_quiet8($sformatf("noise %0d", k), 8'h00);
    end

    // ---------------- loopback framing: start, 8 bits, 2 gap cycles ----------------
    w = 8'hC3;
    pulses = 0; last_cyc = -1; cyc = 0;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 11; c++) begin
        st8 = (c == 0);
        ser8 = (c >= 1 && c <= 8) ? w[c - 1] : 1'b0;
        tick();
        cyc++;
        check("loop err", err8, 0);
        if (valid8) begin
          pulses++;
          check("loop dout", dout8, 8'hC3);
          if (last_cyc >= 0) check("loop period", cyc - last_cyc, 11);
          last_cyc = cyc;
        end
      end
    end
    st8 = 0; ser8 = 0;
    check("loop pulse count", pulses, 3);

    // ---------------- width sweep with scoreboard ----------------
    w2 = 2'b10;
    exp_q.push_back({30'd0, w2});
    st2 = 1; tick();
    st2 = 0;
    for (int k = 0; k < 2; k++) begin
      ser2 = w2[k]; tick();
      check($sformatf("w2 bit%0d valid", k), valid2, k == 1);
      if (valid2) check("w2 dout", dout2, exp_q.pop_front());
    end
    ser2 = 0; tick();
    check("w2 valid drop", valid2, 0);
    check("w2 busy", busy2, 0);

    w32 = $urandom();
    exp_q.push_back(w32);
    st32 = 1; tick();
    st32 = 0;
    for (int k = 0; k < 32; k++) begin
      ser32 = w32[k]; tick();
      check($sformatf("w32 bit%0d valid", k), valid32, k == 31);
      check($sformatf("w32 bit%0d busy", k), busy32, k != 31);
      if (valid32) check("w32 dout", dout32, exp_q.pop_front());
    end
    ser32 = 0; tick();
    check("w32 valid drop", valid32, 0);
    check("scoreboard drained", exp_q.size(), 0);
    check("w2 no err", err2, 0);
    check("w32 no err", err32, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
